led_mode_ctrl: RTL and testbench
================================

// Module: led_mode_ctrl
// PURPOSE
//   Front-panel LED controller for the ECP5 board. Debounces a raw push-button and
//   cycles a mode FSM (OFF -> SLOW -> FAST -> BREATHE -> OFF) on each press.
//   Drives a single LED with the matching pattern: blink via a terminal-count
//   toggle, breathe via PWM with a ramping duty.
//   Sits between the board button pin and the LED pin, replacing the fixed-rate blinker.
// PARAMETERS
//   DEBOUNCE_CYCLES  250_000     btn level must hold this many clk_i cycles to be accepted (>=2)
//   SLOW_MAX         12_500_000  cycles per LED half-period in SLOW (>=2)
//   FAST_MAX         2_500_000   cycles per LED half-period in FAST (>=2)
//   PWM_BITS         8           PWM counter/duty width; PWM period = 2**PWM_BITS cycles
//   STEP_CYCLES      48_828      cycles between duty steps in BREATHE (>=2)
// PORTS
//   clk_i    in   1  system clock, all logic on rising edge
//   rst_ni   in   1  asynchronous active-low reset
//   btn_i    in   1  raw button, active-high, asynchronous to clk_i, may bounce
//   led_o    out  1  LED drive, registered
//   mode_o   out  2  current mode: 0 OFF, 1 SLOW, 2 FAST, 3 BREATHE, registered
// BEHAVIOUR
//   Reset (rst_ni low, async assert): all regs 0; mode_o=0 (OFF); led_o=0; debounced level=0.
//   Sync: btn_i -> 2-flop synchronizer (s1,s2); reset value 0.
//   Debounce: stable reg + counter width $clog2(DEBOUNCE_CYCLES).
//     - s2==stable: counter <= 0.
//     - s2!=stable and counter==DEBOUNCE_CYCLES-1: stable <= s2, counter <= 0.
//     - otherwise counter <= counter+1. Pulses shorter than DEBOUNCE_CYCLES are ignored.
//     - press strobe = (s2 & ~stable & counter==DEBOUNCE_CYCLES-1); one cycle per accepted rise.
//     - Holding the button does not repeat. Release is debounced identically but has no effect.
//   Mode FSM: on press, mode advances OFF->SLOW->FAST->BREATHE->OFF (2-bit wrap).
//     - Update edge is the same edge stable goes 1, i.e. DEBOUNCE_CYCLES+2 edges after btn_i
//       rises (btn_i held clean).
//   Blink (SLOW/FAST): rate counter counts 0..MAX-1, MAX = SLOW_MAX or FAST_MAX per mode.
//     - At MAX-1: counter <= 0 and blink_q <= ~blink_q.
//     - Counter width $clog2(max(SLOW_MAX,FAST_MAX)).
//   Breathe: pwm_cnt free-runs 0..2**PWM_BITS-1, wraps.
//     - step counter 0..STEP_CYCLES-1; at terminal, duty moves +/-1 per dir.
//     - dir up: at duty==2**PWM_BITS-1 the step flips dir to down, duty holds for that step.
//     - dir down: at duty==0 the step flips dir to up, duty holds for that step.
//     - Duty never wraps.
//   Mode change (any press): same edge clears rate counter, blink_q, pwm_cnt, step counter,
//     duty (0) and dir (up). First blink toggle occurs MAX cycles after the mode edge.
//   led_o (registered, 1 cycle after mode_o/source regs):
//     - OFF: 0
//     - SLOW/FAST: blink_q
//     - BREATHE: (pwm_cnt < duty); duty 0 gives constant 0.
//   Reset mid-operation: immediate return to reset state. A press in progress is discarded;
//     the button must be re-held DEBOUNCE_CYCLES after release of reset.
// TESTING (bench params: DEBOUNCE_CYCLES=4 SLOW_MAX=20 FAST_MAX=5 PWM_BITS=3 STEP_CYCLES=8)
//   1. Reset, btn_i=0 for 100 cycles -> mode_o=0, led_o=0 throughout; rst_ni low mid-run forces
//      both 0 asynchronously.
//   2. btn_i high 3 cycles, then low; repeat with 1-cycle bounces -> mode_o stays 0.
//   3. btn_i rises and holds 50 cycles -> mode_o=1 exactly 6 edges after rise, single step only.
//      led_o toggles every 20 cycles, first rise 21 cycles after mode edge.
//   4. Four clean presses -> mode_o 1,2,3,0 in order. In FAST led_o half-period is 5 cycles.
//      In OFF led_o=0 within 1 cycle of mode edge.
//   5. BREATHE 600 cycles -> duty walks 0..7..0 in 8-cycle steps, holding one step at 7 and at 0.
//      led_o high count per 8-cycle PWM window equals duty.
//   6. Press during SLOW with blink_q=1 -> next cycle led_o=0; FAST counter starts from 0.

Source files
------------

// File: rtl/led_mode_ctrl.sv
// Front-panel LED controller: synchronizes and debounces a raw push-button,
// steps a four-mode FSM (OFF -> SLOW -> FAST -> BREATHE -> OFF) on every
// accepted press, and drives one LED with the matching pattern.
// The FSM state is exported directly on mode_o.
module led_mode_ctrl #(
  parameter int DEBOUNCE_CYCLES = 250_000,
  parameter int SLOW_MAX        = 12_500_000,
  parameter int FAST_MAX        = 2_500_000,
  parameter int PWM_BITS        = 8,
  parameter int STEP_CYCLES     = 48_828
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       btn_i,
  output logic       led_o,
  output logic [1:0] mode_o
);

  typedef enum logic [1:0] {
    MODE_OFF     = 2'd0,
    MODE_SLOW    = 2'd1,
    MODE_FAST    = 2'd2,
    MODE_BREATHE = 2'd3
  } mode_e;

  localparam int DB_W     = $clog2(DEBOUNCE_CYCLES);
  localparam int RATE_MAX = (SLOW_MAX > FAST_MAX) ? SLOW_MAX : FAST_MAX;
  localparam int RATE_W   = $clog2(RATE_MAX);
  localparam int STEP_W   = $clog2(STEP_CYCLES);

  localparam logic [DB_W-1:0]     DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [RATE_W-1:0]   SLOW_LAST = RATE_W'(SLOW_MAX - 1);
  localparam logic [RATE_W-1:0]   FAST_LAST = RATE_W'(FAST_MAX - 1);
  localparam logic [STEP_W-1:0]   STEP_LAST = STEP_W'(STEP_CYCLES - 1);
  localparam logic [PWM_BITS-1:0] DUTY_TOP  = '1;

  logic                s1;
  logic                s2;
  logic                stable;
  logic [DB_W-1:0]     db_cnt;
  logic                press;
  mode_e               mode;
  logic [RATE_W-1:0]   rate_cnt;
  logic [RATE_W-1:0]   rate_last;
  logic                blink_q;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [PWM_BITS-1:0] duty;
  logic [STEP_W-1:0]   step_cnt;
  logic                dir_down;   // 0 = ramping up, so the reset value is "up"
  logic                led;

  // Two-flop synchronizer for the asynchronous button pin.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= btn_i;
      s2 <= s1;
    end
  end

  // Debounce: the synchronized level must differ from the accepted level on
  // DEBOUNCE_CYCLES consecutive edges before it is taken as the new level.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stable <= 1'b0;
      db_cnt <= '0;
    end else if (s2 == stable) begin
      db_cnt <= '0;
    end else if (db_cnt == DB_LAST) begin
      stable <= s2;
      db_cnt <= '0;
    end else begin
      db_cnt <= db_cnt + 1'b1;
    end
  end

  // One-cycle strobe on the same edge the accepted level rises.
  assign press = s2 & ~stable & (db_cnt == DB_LAST);

  // Mode FSM: advance one mode per accepted press, wrapping back to OFF.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mode <= MODE_OFF;
    end else if (press) begin
      case (mode)
        MODE_OFF:     mode <= MODE_SLOW;
        MODE_SLOW:    mode <= MODE_FAST;
        MODE_FAST:    mode <= MODE_BREATHE;
        MODE_BREATHE: mode <= MODE_OFF;
        default:      mode <= MODE_OFF;
      endcase
    end
  end

  assign mode_o = mode;

  // Terminal count of the blink half-period for the current mode.
  always_comb begin
    rate_last = FAST_LAST;
    if (mode == MODE_SLOW) rate_last = SLOW_LAST;
  end

  // Blink source: toggle blink_q every MAX cycles while in SLOW or FAST.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rate_cnt <= '0;
      blink_q  <= 1'b0;
    end else if (press) begin
      rate_cnt <= '0;
      blink_q  <= 1'b0;
    end else if (mode == MODE_SLOW || mode == MODE_FAST) begin
      if (rate_cnt == rate_last) begin
        rate_cnt <= '0;
        blink_q  <= ~blink_q;
      end else begin
        rate_cnt <= rate_cnt + 1'b1;
      end
    end else begin
      rate_cnt <= '0;
      blink_q  <= 1'b0;
    end
  end

  // Breathe source: free-running PWM counter plus a duty that ramps up and
  // down one step every STEP_CYCLES, pausing one step at each end.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pwm_cnt  <= '0;
      step_cnt <= '0;
      duty     <= '0;
      dir_down <= 1'b0;
    end else if (press || mode != MODE_BREATHE) begin
      pwm_cnt  <= '0;
      step_cnt <= '0;
      duty     <= '0;
      dir_down <= 1'b0;
    end else begin
      pwm_cnt <= pwm_cnt + 1'b1;
      if (step_cnt == STEP_LAST) begin
        step_cnt <= '0;
        if (!dir_down) begin
          if (duty == DUTY_TOP) dir_down <= 1'b1;
          else                  duty     <= duty + 1'b1;
        end else begin
          if (duty == '0) dir_down <= 1'b0;
          else            duty     <= duty - 1'b1;
        end
      end else begin
        step_cnt <= step_cnt + 1'b1;
      end
    end
  end

  // LED output register: select the pattern for the current mode.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      led <= 1'b0;
    end else begin
      case (mode)
        MODE_OFF:     led <= 1'b0;
        MODE_SLOW:    led <= blink_q;
        MODE_FAST:    led <= blink_q;
        MODE_BREATHE: led <= (pwm_cnt < duty);
        default:      led <= 1'b0;
      endcase
    end
  end

  assign led_o = led;

endmodule

// File: tb/tb_led_mode_ctrl.sv
// Bench for led_mode_ctrl with small parameters. A behavioural model
// (consecutive-edge debounce count, mode index, cycles since the last mode
// change) predicts mode_o and led_o every cycle; hand-written sequences and a
// vector table cover latency, blink timing, breathe windows and resets.
module tb_led_mode_ctrl;

  localparam int DEB   = 4;
  localparam int SLOW  = 20;
  localparam int FAST  = 5;
  localparam int PB    = 3;
  localparam int STEP  = 8;

  logic       clk_i  = 1'b0;
  logic       rst_ni = 1'b0;
  logic       btn_i  = 1'b0;
  logic       led_o;
  logic [1:0] mode_o;

  int checks   = 0;
  int failures = 0;

  // Model state: btn history, accepted level, run length, mode, age of mode.
  int   m_b1, m_b2, m_stable, m_run, m_mode, m_t;
  logic exp_led;

  typedef struct {
    int hold;
    int gap;
    int exp_mode;
  } vec_t;

  vec_t vecs[10];

  led_mode_ctrl #(
    .DEBOUNCE_CYCLES (DEB),
    .SLOW_MAX        (SLOW),
    .FAST_MAX        (FAST),
    .PWM_BITS        (PB),
    .STEP_CYCLES     (STEP)
  ) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .btn_i  (btn_i),
    .led_o  (led_o),
    .mode_o (mode_o)
  );

  // Clock.
  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Duty during the k-th step of BREATHE: triangle 0..N-1, N-1, N-2..0, 0, ...
  function automatic int model_duty(input int k);
    int n = 1 << PB;
    int m = k % (2 * n);
    return (m < n) ? m : (2 * n - 1 - m);
  endfunction

  // LED value produced from a mode that has been active for t edges.
  function automatic logic model_led(input int mode, input int t);
    case (mode)
      1:       return ((t / SLOW) % 2) == 1;
      2:       return ((t / FAST) % 2) == 1;
      3:       return (t % (1 << PB)) < model_duty(t / STEP);
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_reset();
    m_b1 = 0; m_b2 = 0; m_stable = 0; m_run = 0; m_mode = 0; m_t = 0;
    exp_led = 1'b0;
  endtask

  // Advance the model by one rising edge on which btn_i was b.
  task automatic model_edge(input logic b);
    exp_led = model_led(m_mode, m_t);
    m_t++;
    if (m_b2 != m_stable) begin
      m_run++;
      if (m_run == DEB) begin
        m_stable = m_b2;
        m_run = 0;
        if (m_stable == 1) begin
          m_mode = (m_mode + 1) % 4;
          m_t = 0;
        end
      end
    end else begin
      m_run = 0;
    end
    m_b2 = m_b1;
    m_b1 = int'(b);
  endtask

  // Driver: one clock with btn_i = b, then compare both outputs to the model.
  task automatic cycle(input logic b);
    btn_i = b;
    @(posedge clk_i);
    model_edge(b);
    @(negedge clk_i);
    check("mode_o", int'(mode_o), m_mode);
    check("led_o", int'(led_o), int'(exp_led));
  endtask

  task automatic hold(input logic b, input int n);
    repeat (n) cycle(b);
  endtask

  // Assert reset between edges, check outputs clear immediately.
  task automatic apply_reset(input int n);
    #3 rst_ni = 1'b0;
    model_reset();
    #1;
    check("async_reset_mode", int'(mode_o), 0);
    check("async_reset_led", int'(led_o), 0);
    repeat (n) @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  // Hold the button until the mode reaches exp_mode; returns at the mode edge.
  task automatic press_to_edge(input int exp_mode);
    int n = 1;
    cycle(1'b1);
    while (int'(mode_o) != exp_mode && n < 12) begin
      cycle(1'b1);
      n++;
    end
    check("press_to_mode", int'(mode_o), exp_mode);
    check("press_latency", n, DEB + 2);
  endtask

  // Global time limit.
  initial begin
    #2_000_000;
    failures++;
    $display("FAIL watchdog: got timeout expected finish at %0t", $time);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    int mode_edge, rise, fall, off, cnt, h, g;

    vecs[0] = '{3, 12, 0};
    vecs[1] = '{1, 12, 0};
    vecs[2] = '{2, 12, 0};
    vecs[3] = '{4, 12, 1};
    vecs[4] = '{50, 12, 2};
    vecs[5] = '{6, 12, 3};
    vecs[6] = '{8, 12, 0};
    vecs[7] = '{5, 12, 1};
    vecs[8] = '{3, 12, 1};
    vecs[9] = '{20, 12, 2};

    // Reset.
    model_reset();
    repeat (3) @(negedge clk_i);
    check("reset_mode", int'(mode_o), 0);
    check("reset_led", int'(led_o), 0);
    rst_ni = 1'b1;

    // Idle button.
    hold(1'b0, 100);

    // Short pulses and bounces are ignored.
    hold(1'b1, 3);
    hold(1'b0, 10);
    for (int i = 0; i < 6; i++) begin
      hold(1'b1, 1);
      hold(1'b0, 1);
    end
    hold(1'b0, 10);
    check("bounce_mode", int'(mode_o), 0);

    // Clean 50-cycle hold: press latency, no repeat, SLOW blink timing.
    mode_edge = -1; rise = -1; fall = -1;
    for (int i = 1; i <= 50; i++) begin
      cycle(1'b1);
      if (mode_edge < 0 && mode_o == 2'd1) mode_edge = i;
      if (mode_edge >= 0 && i > mode_edge) begin
        if (rise < 0 && led_o == 1'b1) rise = i - mode_edge;
        if (rise >= 0 && fall < 0 && led_o == 1'b0) fall = i - mode_edge;
      end
    end
    check("first_press_edge", mode_edge, DEB + 2);
    check("slow_first_rise", rise, SLOW + 1);
    check("slow_first_fall", fall, 2 * SLOW + 1);
    check("hold_no_repeat", int'(mode_o), 1);
    hold(1'b0, 10);

    // Press while the SLOW blink is high: LED drops, FAST starts from zero.
    off = 0;
    while (led_o == 1'b0 && off < 50) begin
      cycle(1'b0);
      off++;
    end
    check("slow_led_high", int'(led_o), 1);
    press_to_edge(2);
    check("led_before_press", int'(led_o), 1);
    cycle(1'b0);
    check("led_cleared", int'(led_o), 0);
    off = 1;
    while (led_o == 1'b0 && off < 30) begin
      cycle(1'b0);
      off++;
    end
    check("fast_first_rise", off, FAST + 1);
    while (led_o == 1'b1 && off < 60) begin
      cycle(1'b0);
      off++;
    end
    check("fast_first_fall", off, 2 * FAST + 1);
    hold(1'b0, 20);

    // BREATHE for 600 cycles: LED-high count per 8-cycle window equals duty.
    press_to_edge(3);
    for (int j = 0; j < 75; j++) begin
      cnt = 0;
      for (int k = 0; k < (1 << PB); k++) begin
        cycle(1'b0);
        cnt += int'(led_o);
      end
      check("breathe_window", cnt, model_duty(j));
    end
    hold(1'b0, 10);

    // Back to OFF: LED low within one cycle.
    press_to_edge(0);
    cycle(1'b0);
    check("off_led", int'(led_o), 0);
    hold(1'b0, 20);

    // Vector table of pulse lengths.
    for (int v = 0; v < 10; v++) begin
      hold(1'b1, vecs[v].hold);
      hold(1'b0, vecs[v].gap);
      check("vec_mode", int'(mode_o), vecs[v].exp_mode);
    end

    // Reset mid-run and reset during a press in progress.
    hold(1'b0, 7);
    apply_reset(3);
    hold(1'b0, 10);
    hold(1'b1, 3);
    apply_reset(2);
    hold(1'b1, 10);
    check("press_after_reset", int'(mode_o), 1);
    hold(1'b0, 10);

    // Random presses, bounces and resets against the model.
    for (int r = 0; r < 40; r++) begin
      h = $urandom_range(1, 10);
      g = $urandom_range(1, 30);
      hold(1'b1, h);
      hold(1'b0, g);
      if ($urandom_range(0, 15) == 0) apply_reset($urandom_range(1, 3));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
